people_move_ctrl: RTL and testbench

- Player-character controller directly upstream of the stage renderer.
- Holds the character position and steps it on a frame tick from one-hot direction keys. Moves are rejected if the foot point would leave the walkable floor of stage 1.
- Drives the people bounding-box borders to the stage mixer and a registered sprite-ROM address; people_pixel is the ROM output of that address.
- Flags arrival at the door region.

---
 rtl/people_move_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_people_move_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/people_move_ctrl.sv
// Player-character controller: steps the character position on a frame tick after
// checking the screen limits and the stage-1 floor, and builds the sprite ROM address.
//
// state    | meaning
// S_IDLE   | waiting for a tick; latches facing and the candidate position on a keyed tick
// S_CHECK  | registers whether the candidate passes the screen clamp and floor test
// S_COMMIT | applies the candidate if accepted (moving pulses), then back to S_IDLE
module people_move_ctrl #(
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32,
    parameter int STEP     = 2,
    parameter int TICK_DIV = 1666667,
    parameter int INIT_X   = 300,
    parameter int INIT_Y   = 300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic [9:0]  people_left_border,
    output logic [9:0]  people_right_border,
    output logic [9:0]  people_up_border,
    output logic [9:0]  people_down_border,
    output logic [13:0] sprite_addr,
    output logic        at_door,
    output logic        moving
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int COL_W = $clog2(SPRITE_W);
    localparam int ROW_W = $clog2(SPRITE_H);
    localparam logic signed [10:0] STEP_S  = 11'(STEP);
    localparam logic signed [10:0] HALF_W  = 11'(SPRITE_W / 2);
    localparam logic signed [10:0] FOOT_DY = 11'(SPRITE_H - 1);
    localparam logic signed [10:0] MAX_X   = 11'(639 - SPRITE_W);
    localparam logic signed [10:0] MAX_Y   = 11'(479 - SPRITE_H);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_COMMIT} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic [9:0]       pos_x, pos_y, pos_x_nxt, pos_y_nxt;
    logic [1:0]       facing, facing_nxt, anim, anim_nxt, dir;
    logic signed [10:0] cand_x, cand_y, cand_x_nxt, cand_y_nxt;
    logic signed [10:0] cand_x_dir, cand_y_dir, pos_xs, pos_ys;
    logic signed [10:0] cfx, cfy, dfx, dfy;
    logic             ok, ok_nxt, key_any, clamp_ok, foot_ok, in_win;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    function automatic logic in_rect(input logic signed [10:0] fx, fy,
                                     input logic signed [10:0] x0, x1, y0, y1);
        return (fx >= x0) && (fx <= x1) && (fy >= y0) && (fy <= y1);
    endfunction

    assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + CNT_W'(1);
    end

    assign pos_xs  = {1'b0, pos_x};
    assign pos_ys  = {1'b0, pos_y};
    assign key_any = key_up | key_down | key_left | key_right;

    always_comb begin
        if (key_up)        dir = 2'b00;
        else if (key_down) dir = 2'b01;
        else if (key_left) dir = 2'b10;
        else               dir = 2'b11;
        cand_x_dir = pos_xs;
        cand_y_dir = pos_ys;
        case (dir)
            2'b00: cand_y_dir = pos_ys - STEP_S;
            2'b01: cand_y_dir = pos_ys + STEP_S;
            2'b10: cand_x_dir = pos_xs - STEP_S;
            2'b11: cand_x_dir = pos_xs + STEP_S;
        endcase
    end

    // Signed candidate so a step past 0 fails the clamp instead of wrapping.
    assign clamp_ok = (cand_x >= 11'sd0) && (cand_x <= MAX_X) &&
                      (cand_y >= 11'sd0) && (cand_y <= MAX_Y);
    assign cfx = cand_x + HALF_W;
    assign cfy = cand_y + FOOT_DY;
    assign foot_ok = in_rect(cfx, cfy, 11'sd220, 11'sd320, 11'sd75,  11'sd220) ||
                     in_rect(cfx, cfy, 11'sd350, 11'sd420, 11'sd10,  11'sd220) ||
                     in_rect(cfx, cfy, 11'sd120, 11'sd520, 11'sd220, 11'sd350) ||
                     in_rect(cfx, cfy, 11'sd220, 11'sd420, 11'sd350, 11'sd380) ||
                     in_rect(cfx, cfy, 11'sd250, 11'sd290, 11'sd10,  11'sd80);

    assign dfx     = pos_xs + HALF_W;
    assign dfy     = pos_ys + FOOT_DY;
    assign at_door = in_rect(dfx, dfy, 11'sd250, 11'sd290, 11'sd10, 11'sd80);

    always_comb begin
        state_nxt  = state;
        pos_x_nxt  = pos_x;
        pos_y_nxt  = pos_y;
        facing_nxt = facing;
        anim_nxt   = anim;
        cand_x_nxt = cand_x;
        cand_y_nxt = cand_y;
        ok_nxt     = ok;
        moving     = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick) begin
                    if (key_any) begin
                        facing_nxt = dir;
                        cand_x_nxt = cand_x_dir;
                        cand_y_nxt = cand_y_dir;
                        state_nxt  = S_CHECK;
                    end else begin
                        anim_nxt = 2'd0;
                    end
                end
            end
            S_CHECK: begin
                ok_nxt    = clamp_ok && foot_ok;
                state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                if (ok) begin
                    pos_x_nxt = cand_x[9:0];
                    pos_y_nxt = cand_y[9:0];
                    anim_nxt  = anim + 2'd1;
                    moving    = 1'b1;
                end
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            pos_x  <= 10'(INIT_X);
            pos_y  <= 10'(INIT_Y);
            facing <= 2'b01;
            anim   <= 2'd0;
            cand_x <= '0;
            cand_y <= '0;
            ok     <= 1'b0;
        end else begin
            state  <= state_nxt;
            pos_x  <= pos_x_nxt;
            pos_y  <= pos_y_nxt;
            facing <= facing_nxt;
            anim   <= anim_nxt;
            cand_x <= cand_x_nxt;
            cand_y <= cand_y_nxt;
            ok     <= ok_nxt;
        end
    end

    assign people_left_border  = pos_x;
    assign people_right_border = pos_x + 10'(SPRITE_W);
    assign people_up_border    = pos_y;
    assign people_down_border  = pos_y + 10'(SPRITE_H);

    // Window is (left, right] x (up, down]; the ROM adds the second cycle of latency.
    assign in_win = (x > people_left_border) && (x <= people_right_border) &&
                    (y > people_up_border)   && (y <= people_down_border);
    assign col = COL_W'(x - people_left_border - 10'd1);
    assign row = ROW_W'(y - people_up_border - 10'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         sprite_addr <= '0;
        else if (in_win) sprite_addr <= 14'({facing, anim, row, col});
        else             sprite_addr <= '0;
    end
endmodule

// File: tb/tb_people_move_ctrl.sv
// Bench for people_move_ctrl: four instances with different start positions, a
// behavioural position/facing/anim model, and a queue of expected step results.
module tb_people_move_ctrl;
    localparam int TD = 4;
    localparam bit [3:0][9:0] IX = {10'd254, 10'd0, 10'd100, 10'd300};
    localparam bit [3:0][9:0] IY = {10'd52, 10'd300, 10'd300, 10'd300};
    localparam logic [3:0] K_UP = 4'b1000, K_DOWN = 4'b0100, K_LEFT = 4'b0010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic [3:0] keys [4];
    logic [9:0] lb [4], rb [4], ub [4], db [4];
    logic [13:0] sa [4];
    logic door [4], mov [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        people_move_ctrl #(.TICK_DIV(TD), .INIT_X(int'(IX[g])), .INIT_Y(int'(IY[g]))) u_dut (
            .clk(clk), .rst(rst),
            .key_up(keys[g][3]), .key_down(keys[g][2]), .key_left(keys[g][1]), .key_right(keys[g][0]),
            .x(x), .y(y),
            .people_left_border(lb[g]), .people_right_border(rb[g]),
            .people_up_border(ub[g]), .people_down_border(db[g]),
            .sprite_addr(sa[g]), .at_door(door[g]), .moving(mov[g])
        );
    end

    int edge_n;
    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    int mcnt [4] = '{0, 0, 0, 0};
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (mov[i]) mcnt[i] <= mcnt[i] + 1;
    end

    typedef struct { int i; int px; int py; logic [1:0] f; logic [1:0] a; int mv; } exp_t;
    exp_t sb [$];
    int mx [4], my [4];
    logic [1:0] mf [4], ma [4];
    int checks = 0;
    int errors = 0;

    function automatic bit in_r(int fx, int fy, int x0, int x1, int y0, int y1);
        return fx >= x0 && fx <= x1 && fy >= y0 && fy <= y1;
    endfunction

    function automatic bit floor_ok(int cx, int cy);
        int fx = cx + 16;
        int fy = cy + 31;
        return in_r(fx, fy, 220, 320, 75, 220) || in_r(fx, fy, 350, 420, 10, 220) ||
               in_r(fx, fy, 120, 520, 220, 350) || in_r(fx, fy, 220, 420, 350, 380) ||
               in_r(fx, fy, 250, 290, 10, 80);
    endfunction

    function automatic bit door_exp(int px, int py);
        return in_r(px + 16, py + 31, 250, 290, 10, 80);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mx[i] = int'(IX[i]); my[i] = int'(IY[i]); mf[i] = 2'b01; ma[i] = 2'd0;
        end
    endtask

    task automatic wait_tick_edge();
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (edge_n % TD != 0 && n < 16);
        checks++;
        if (edge_n % TD != 0) begin
            errors++;
            $display("FAIL tick_wait: edge %0d, expected a multiple of %0d", edge_n, TD);
        end
    endtask

    // One tick with keys k on instance i; checks pos, door, moving, facing/anim.
    task automatic run_tick(input int i, input logic [3:0] k);
        exp_t e;
        int c0, cx, cy;
        logic [1:0] d;
        c0 = mcnt[i];
        keys[i] = k;
        e.mv = 0;
        if (k != 4'b0) begin
            d = k[3] ? 2'd0 : k[2] ? 2'd1 : k[1] ? 2'd2 : 2'd3;
            mf[i] = d; cx = mx[i]; cy = my[i];
            case (d)
                2'd0: cy -= 2;
                2'd1: cy += 2;
                2'd2: cx -= 2;
                default: cx += 2;
            endcase
            if (cx >= 0 && cx <= 607 && cy >= 0 && cy <= 447 && floor_ok(cx, cy)) begin
                mx[i] = cx; my[i] = cy; ma[i] = ma[i] + 2'd1; e.mv = 1;
            end
        end else begin
            ma[i] = 2'd0;
        end
        e.i = i; e.px = mx[i]; e.py = my[i]; e.f = mf[i]; e.a = ma[i];
        sb.push_back(e);
        wait_tick_edge();
        @(negedge clk); keys[i] = 4'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        e = sb.pop_front();
        checks += 6;
        if (lb[e.i] !== 10'(e.px)) begin errors++; $display("FAIL left inst%0d: got %0d, expected %0d", e.i, lb[e.i], e.px); end
        if (rb[e.i] !== 10'(e.px + 32)) begin errors++; $display("FAIL right inst%0d: got %0d, expected %0d", e.i, rb[e.i], e.px + 32); end
        if (ub[e.i] !== 10'(e.py)) begin errors++; $display("FAIL up inst%0d: got %0d, expected %0d", e.i, ub[e.i], e.py); end
        if (db[e.i] !== 10'(e.py + 32)) begin errors++; $display("FAIL down inst%0d: got %0d, expected %0d", e.i, db[e.i], e.py + 32); end
        if (door[e.i] !== door_exp(e.px, e.py)) begin errors++; $display("FAIL at_door inst%0d: got %0b, expected %0b", e.i, door[e.i], door_exp(e.px, e.py)); end
        if (mcnt[e.i] - c0 != e.mv) begin errors++; $display("FAIL moving inst%0d: got %0d pulses, expected %0d", e.i, mcnt[e.i] - c0, e.mv); end
        x = 10'(e.px + 1); y = 10'(e.py + 1);
        @(posedge clk); #1;
        checks++;
        if (sa[e.i] !== {e.f, e.a, 10'd0}) begin errors++; $display("FAIL facing_anim inst%0d: got %h, expected %h", e.i, sa[e.i], {e.f, e.a, 10'd0}); end
        x = '0; y = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks += 7;
        if (lb[0] !== 10'd300 || ub[0] !== 10'd300) begin errors++; $display("FAIL rst_pos: got %0d,%0d, expected 300,300", lb[0], ub[0]); end
        if (rb[0] !== 10'd332 || db[0] !== 10'd332) begin errors++; $display("FAIL rst_rd: got %0d,%0d, expected 332,332", rb[0], db[0]); end
        if (door[0] !== 1'b0) begin errors++; $display("FAIL rst_door: got %0b, expected 0", door[0]); end
        if (mov[0] !== 1'b0) begin errors++; $display("FAIL rst_moving: got %0b, expected 0", mov[0]); end
        if (sa[0] !== 14'd0) begin errors++; $display("FAIL rst_addr: got %h, expected 0", sa[0]); end
        if (lb[3] !== 10'd254 || ub[3] !== 10'd52) begin errors++; $display("FAIL rst_pos3: got %0d,%0d, expected 254,52", lb[3], ub[3]); end
        if (door[3] !== 1'b0) begin errors++; $display("FAIL rst_door3: got %0b, expected 0", door[3]); end
        x = 10'd301; y = 10'd301;
        @(posedge clk); #1;
        checks++;
        if (sa[0] !== 14'h1000) begin errors++; $display("FAIL rst_facing: got %h, expected 1000", sa[0]); end
        x = '0; y = '0;
    endtask

    task automatic test_single_up();
        run_tick(0, K_UP);
    endtask

    // Runs on the tick right after test_single_up so anim reaches 2.
    task automatic test_sprite_addr();
        run_tick(0, K_DOWN);
        @(negedge clk); x = 10'd311; y = 10'd306;
        @(posedge clk); #1;
        checks++;
        if (sa[0] !== 14'b01_10_00101_01010) begin errors++; $display("FAIL sprite_in: got %h, expected %h", sa[0], 14'b01_10_00101_01010); end
        @(negedge clk); x = 10'd300;
        @(posedge clk); #1;
        checks++;
        if (sa[0] !== 14'd0) begin errors++; $display("FAIL sprite_edge: got %h, expected 0", sa[0]); end
        x = '0; y = '0;
        ma[0] = 2'd0;
    endtask

    task automatic test_priority_blocked();
        run_tick(0, K_UP | K_LEFT);
        run_tick(1, K_LEFT);
    endtask

    task automatic test_clamp();
        run_tick(2, K_LEFT);
    endtask

    task automatic test_door();
        ma[3] = 2'd0;
        for (int s = 0; s < 28; s++) run_tick(3, K_UP);
        checks++;
        if (ub[3] !== 10'd0) begin errors++; $display("FAIL door_top: got %0d, expected 0", ub[3]); end
    endtask

    task automatic test_reset_abort();
        int c0;
        c0 = mcnt[0];
        keys[0] = K_UP;
        wait_tick_edge();
        @(negedge clk); rst = 1'b1; keys[0] = 4'b0;
        @(negedge clk); rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (ub[0] !== 10'd300 || lb[0] !== 10'd300) begin errors++; $display("FAIL abort_pos: got %0d,%0d, expected 300,300", lb[0], ub[0]); end
        if (mcnt[0] != c0) begin errors++; $display("FAIL abort_moving: got %0d pulses, expected 0", mcnt[0] - c0); end
        run_tick(0, K_DOWN);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) keys[i] = 4'b0;
        model_reset();
        test_reset();
        test_single_up();
        test_sprite_addr();
        test_priority_blocked();
        test_clamp();
        test_door();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
